// File: rtl/nn_pkg.sv
// Shared types and default sizing for the NN weight dispatch path.
// No logic; state/mode enums and default parameter values only.
// Backpressure handling lives in the modules that import this package.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } dispatch_state_t;

    typedef enum logic {
        ADDR = 1'b0,
        SEQ  = 1'b1
    } dispatch_mode_t;

    localparam int NN_N_CH   = 16;
    localparam int NN_DATA_W = 16;
    localparam int NN_DEPTH  = 64;

endpackage

// File: rtl/nn_onehot_dec.sv
// Select-to-one-hot decoder with enable and out-of-range flag.
// Latency: combinational.
// Backpressure: none; a pure function of sel/en.
module nn_onehot_dec #(
    parameter int N_CH  = 16,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N_CH-1:0]  onehot,
    output logic             oor
);

    localparam logic [SEL_W:0]  SEL_LIM = N_CH[SEL_W:0];
    localparam logic [N_CH-1:0] ONE     = {{(N_CH-1){1'b0}}, 1'b1};

    // Non-power-of-two channel counts leave select codes with no FIFO behind them.
    assign oor    = ({1'b0, sel} >= SEL_LIM);
    assign onehot = (en && !oor) ? (ONE << sel) : '0;

endmodule

// File: rtl/nn_weight_dispatch.sv
// Registered weight-word dispatcher into N_CH FIFOs, addressed or sequential fill; NN_DISPATCH_BCAST_EN adds a broadcast input.
// Latency: accepted word shows on wr_en/wr_data one cycle later, one word per cycle sustained.
// Backpressure: in_ready drops when the target FIFO (any FIFO for broadcast) reports full; sequencer holds in place.
module nn_weight_dispatch
    import nn_pkg::*;
#(
    parameter int  N_CH   = NN_N_CH,
    parameter int  DATA_W = NN_DATA_W,
    parameter int  DEPTH  = NN_DEPTH,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              start,
`ifdef NN_DISPATCH_BCAST_EN
    input  logic              bcast,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [N_CH-1:0]   fifo_full,
    output logic [N_CH-1:0]   wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              sel_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAST_WORD_I = DEPTH - 1;
    localparam int LAST_CH_I   = N_CH - 1;
    localparam logic [CNT_W-1:0] LAST_WORD = LAST_WORD_I[CNT_W-1:0];
    localparam logic [SEL_W-1:0] LAST_CH   = LAST_CH_I[SEL_W-1:0];

    dispatch_state_t   state;
    logic [CNT_W-1:0]  word_cnt;
    logic [SEL_W-1:0]  ch_ptr;
    logic [SEL_W-1:0]  tgt_sel;
    logic [N_CH-1:0]   tgt_oh;
    logic              tgt_oor;
    logic              tgt_full;
    logic              bcast_w;
    logic              ready_c;
    logic              accept;
    logic              addr_mode;

`ifdef NN_DISPATCH_BCAST_EN
    assign bcast_w = bcast;
`else
    assign bcast_w = 1'b0;
`endif

    assign addr_mode = (dispatch_mode_t'(mode) == ADDR);
    assign tgt_sel   = (state == FILL) ? ch_ptr : in_sel;

    nn_onehot_dec #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_tgt_dec (
        .sel    (tgt_sel),
        .en     (1'b1),
        .onehot (tgt_oh),
        .oor    (tgt_oor)
    );

    // Masking with the decoded target avoids indexing fifo_full with an out-of-range select.
    assign tgt_full = |(tgt_oh & fifo_full);

    always_comb begin
        ready_c = 1'b0;
        case (state)
            IDLE: begin
                if (addr_mode) begin
                    if (bcast_w)      ready_c = ~|fifo_full;
                    else if (tgt_oor) ready_c = 1'b1;
                    else              ready_c = ~tgt_full;
                end
            end
            FILL:    ready_c = ~tgt_full;
            default: ready_c = 1'b0;
        endcase
    end

    assign in_ready = ready_c & rst_n;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            word_cnt <= '0;
            ch_ptr   <= '0;
            wr_en    <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            wr_en   <= '0;
            done    <= 1'b0;
            sel_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (addr_mode) begin
                        if (accept) begin
                            if (bcast_w) begin
                                wr_en   <= '1;
                                wr_data <= in_data;
                            end else if (tgt_oor) begin
                                sel_err <= 1'b1;
                            end else begin
                                wr_en   <= tgt_oh;
                                wr_data <= in_data;
                            end
                        end
                    end else if (start) begin
                        state    <= FILL;
                        ch_ptr   <= '0;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        wr_en   <= tgt_oh;
                        wr_data <= in_data;
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            if (ch_ptr == LAST_CH) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                ch_ptr <= ch_ptr + 1'b1;
                            end
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_weight_dispatch.sv
// Bench for nn_weight_dispatch: directed cases on 16/4-channel instances, random run on a 12-channel instance.
module tb_nn_weight_dispatch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // 16-channel instance, default depth
    logic a_mode = 0, a_start = 0, a_valid = 0, a_ready, a_busy, a_done, a_sel_err;
    logic [15:0] a_data = '0, a_full = '0, a_wr_en, a_wr_data;
    logic [3:0]  a_sel = '0;
`ifdef NN_DISPATCH_BCAST_EN
    logic a_bcast = 0;
`endif

    // 4-channel, depth 3 instance
    logic s_mode = 0, s_start = 0, s_valid = 0, s_ready, s_busy, s_done, s_sel_err;
    logic [15:0] s_data = '0, s_wr_data;
    logic [3:0]  s_full = '0, s_wr_en;
    logic [1:0]  s_sel = '0;

    // 12-channel, depth 3 instance
    logic r_mode = 0, r_start = 0, r_valid = 0, r_ready, r_busy, r_done, r_sel_err;
    logic [15:0] r_data = '0, r_wr_data;
    logic [11:0] r_full = '0, r_wr_en;
    logic [3:0]  r_sel = '0;

    nn_weight_dispatch #(.N_CH(16), .DATA_W(16), .DEPTH(64)) u_a (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .start(a_start),
`ifdef NN_DISPATCH_BCAST_EN
        .bcast(a_bcast),
`endif
        .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data), .in_sel(a_sel),
        .fifo_full(a_full), .wr_en(a_wr_en), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done), .sel_err(a_sel_err)
    );

    nn_weight_dispatch #(.N_CH(4), .DATA_W(16), .DEPTH(3)) u_s (
        .clk(clk), .rst_n(rst_n), .mode(s_mode), .start(s_start),
`ifdef NN_DISPATCH_BCAST_EN
        .bcast(1'b0),
`endif
        .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data), .in_sel(s_sel),
        .fifo_full(s_full), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .busy(s_busy), .done(s_done), .sel_err(s_sel_err)
    );

    nn_weight_dispatch #(.N_CH(12), .DATA_W(16), .DEPTH(3)) u_r (
        .clk(clk), .rst_n(rst_n), .mode(r_mode), .start(r_start),
`ifdef NN_DISPATCH_BCAST_EN
        .bcast(1'b0),
`endif
        .in_valid(r_valid), .in_ready(r_ready), .in_data(r_data), .in_sel(r_sel),
        .fifo_full(r_full), .wr_en(r_wr_en), .wr_data(r_wr_data),
        .busy(r_busy), .done(r_done), .sel_err(r_sel_err)
    );

    // Reference model state for the random run: fills tracked as a linear word count.
    int          m_phase = 0;   // 0 idle, 1 filling, 2 done cycle
    int          m_n = 0;
    logic [11:0] e_wr = '0;
    logic [15:0] e_dat = '0;
    logic        e_busy = 0, e_done = 0, e_err = 0;
    logic        e_rdy;
    logic        acc;
    int          busy_cnt, done_cnt;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", a_ready, 0);
        check("rst_wr_en", a_wr_en, 0);
        check("rst_wr_data", a_wr_data, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_sel_err", a_sel_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Addressed mode, back-to-back words to every channel
        a_mode = 0;
        a_valid = 1;
        for (int k = 0; k < 16; k++) begin
            a_sel = 4'(k);
            a_data = 16'hA001 + 16'(k);
            #1 check("addr_ready", a_ready, 1);
            @(negedge clk);
            check("addr_wr_en", a_wr_en, 16'(1) << k);
            check("addr_wr_data", a_wr_data, 16'hA001 + 16'(k));
        end

        // Backpressure on channel 5
        a_sel = 4'd5;
        a_data = 16'h5555;
        a_full = 16'h0020;
        for (int c = 0; c < 3; c++) begin
            #1 check("bp_ready", a_ready, 0);
            @(negedge clk);
            check("bp_no_wr", a_wr_en, 0);
        end
        a_full = '0;
        #1 check("bp_release_ready", a_ready, 1);
        @(negedge clk);
        check("bp_release_wr", a_wr_en, 16'h0020);
        check("bp_release_data", a_wr_data, 16'h5555);
        a_valid = 0;
        @(negedge clk);
        check("bp_single_wr", a_wr_en, 0);

`ifdef NN_DISPATCH_BCAST_EN
        a_bcast = 1;
        a_sel = 4'd7;
        a_data = 16'h1234;
        a_valid = 1;
        #1 check("bcast_ready", a_ready, 1);
        @(negedge clk);
        check("bcast_wr_en", a_wr_en, 16'hFFFF);
        check("bcast_wr_data", a_wr_data, 16'h1234);
        check("bcast_no_err", a_sel_err, 0);
        a_full = 16'h0200;
        #1 check("bcast_full_ready", a_ready, 0);
        @(negedge clk);
        check("bcast_full_no_wr", a_wr_en, 0);
        a_valid = 0;
        a_bcast = 0;
        a_full = '0;
`endif

        // Sequential fill, 4 channels x 3 words
        s_mode = 1;
        s_start = 1;
        #1 check("seq_idle_ready", s_ready, 0);
        @(negedge clk);
        s_start = 0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            busy_cnt += int'(s_busy);
            done_cnt += int'(s_done);
            if (i >= 1 && i <= 12) begin
                check("seq_wr_en", s_wr_en, 4'(1) << ((i - 1) / 3));
                check("seq_wr_data", s_wr_data, 16'hB000 + 16'(i - 1));
            end else begin
                check("seq_idle_wr", s_wr_en, 0);
            end
            if (i == 6) s_mode = 0;   // must not disturb an active fill
            s_valid = (i < 12);
            s_data = 16'hB000 + 16'(i);
            if (i < 12) begin
                #1 check("seq_ready", s_ready, 1);
            end
            @(negedge clk);
        end
        s_valid = 0;
        check("seq_busy_cycles", busy_cnt, 12);
        check("seq_done_pulses", done_cnt, 1);

        // Reset in the middle of a fill
        s_mode = 1;
        s_start = 1;
        @(negedge clk);
        s_start = 0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1;
            s_data = 16'hC000 + 16'(i);
            @(negedge clk);
        end
        check("rstfill_pre_wr", s_wr_en, 4'b0010);
        #2 rst_n = 0;
        #1;
        check("rstfill_wr_en", s_wr_en, 0);
        check("rstfill_busy", s_busy, 0);
        check("rstfill_ready", s_ready, 0);
        check("rstfill_data", s_wr_data, 0);
        @(negedge clk);
        rst_n = 1;
        s_valid = 0;
        @(negedge clk);
        s_start = 1;
        @(negedge clk);
        s_start = 0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1;
            s_data = 16'hD000 + 16'(i);
            @(negedge clk);
            check("refill_wr_en", s_wr_en, (i < 3) ? 4'b0001 : 4'b0010);
            check("refill_wr_data", s_wr_data, 16'hD000 + 16'(i));
        end
        s_valid = 0;

        // Out-of-range select on the 12-channel instance
        @(negedge clk);
        r_mode = 0;
        r_sel = 4'd13;
        r_valid = 1;
        #1 check("oor_ready", r_ready, 1);
        @(negedge clk);
        check("oor_no_wr", r_wr_en, 0);
        check("oor_sel_err", r_sel_err, 1);
        r_valid = 0;
        @(negedge clk);
        check("oor_err_one_cycle", r_sel_err, 0);

        // Random run against the reference model
        for (int t = 0; t < 600; t++) begin
            check("rnd_wr_en", r_wr_en, e_wr);
            if (e_wr != 0) check("rnd_wr_data", r_wr_data, e_dat);
            check("rnd_busy", r_busy, e_busy);
            check("rnd_done", r_done, e_done);
            check("rnd_sel_err", r_sel_err, e_err);

            r_mode  = 1'($urandom_range(0, 1));
            r_start = ($urandom_range(0, 3) == 0);
            r_valid = ($urandom_range(0, 3) != 0);
            r_sel   = 4'($urandom_range(0, 15));
            r_full  = 12'($urandom & $urandom);
            r_data  = 16'($urandom);
            #1;
            if (m_phase == 0)      e_rdy = r_mode ? 1'b0 : ((r_sel >= 4'd12) ? 1'b1 : !r_full[r_sel]);
            else if (m_phase == 1) e_rdy = !r_full[m_n / 3];
            else                   e_rdy = 1'b0;
            check("rnd_ready", r_ready, e_rdy);

            acc = r_valid && e_rdy;
            e_wr = '0;
            e_done = 0;
            e_err = 0;
            if (m_phase == 0) begin
                if (!r_mode) begin
                    if (acc && r_sel >= 4'd12) e_err = 1;
                    else if (acc) begin
                        e_wr = 12'(1) << r_sel;
                        e_dat = r_data;
                    end
                end else if (r_start) begin
                    m_phase = 1;
                    m_n = 0;
                end
            end else if (m_phase == 1) begin
                if (acc) begin
                    e_wr = 12'(1) << (m_n / 3);
                    e_dat = r_data;
                    m_n++;
                    if (m_n == 36) begin
                        m_phase = 2;
                        e_done = 1;
                    end
                end
            end else begin
                m_phase = 0;
            end
            e_busy = (m_phase == 1);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
